// File: rtl/traffic_light_4way.sv
// Four-way intersection controller: north-south and east-west lamps cycle
// green -> yellow -> (all-red) with per-phase dwell times set by parameters.
// Define TL4_ALL_RED_EN to insert the ALL_RED_1/ALL_RED_2 clearance phases;
// without it the yellow phases hand over directly to the opposing green.
// Lamp encoding is {red,yellow,green}; outputs are registered.
module traffic_light_4way #(
  parameter int unsigned GREEN_TIME  = 5,
  parameter int unsigned YELLOW_TIME = 2,
  parameter int unsigned ALLRED_TIME = 1
) (
  input  logic       clk,
  input  logic       reset,
  output logic [2:0] ns_light,
  output logic [2:0] ew_light
);

  localparam logic [2:0] LAMP_RED    = 3'b100;
  localparam logic [2:0] LAMP_YELLOW = 3'b010;
  localparam logic [2:0] LAMP_GREEN  = 3'b001;

  // Last dwell-counter value of each phase; a zero parameter behaves as 1.
  localparam logic [7:0] GREEN_LAST  = 8'((GREEN_TIME  == 0) ? 0 : GREEN_TIME  - 1);
  localparam logic [7:0] YELLOW_LAST = 8'((YELLOW_TIME == 0) ? 0 : YELLOW_TIME - 1);
`ifdef TL4_ALL_RED_EN
  localparam logic [7:0] ALLRED_LAST = 8'((ALLRED_TIME == 0) ? 0 : ALLRED_TIME - 1);
`endif

  typedef enum logic [2:0] {
    NS_GREEN  = 3'd0,
    NS_YELLOW = 3'd1,
    ALL_RED_1 = 3'd2,
    EW_GREEN  = 3'd3,
    EW_YELLOW = 3'd4,
    ALL_RED_2 = 3'd5
  } state_t;

  state_t     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic [2:0] ns_q, ns_d;
  logic [2:0] ew_q, ew_d;

  logic [7:0] dwell_last;
  state_t     next_phase;
  logic       illegal;

  // Next phase, dwell counter and the lamp pattern of the phase being entered.
  // Lamps are decoded from state_d so the registered outputs line up with
  // the registered state.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q + 8'd1;
    dwell_last = GREEN_LAST;
    next_phase = NS_GREEN;
    illegal    = 1'b0;

    case (state_q)
      NS_GREEN: begin
        dwell_last = GREEN_LAST;
        next_phase = NS_YELLOW;
      end
      NS_YELLOW: begin
        dwell_last = YELLOW_LAST;
`ifdef TL4_ALL_RED_EN
        next_phase = ALL_RED_1;
`else
        next_phase = EW_GREEN;
`endif
      end
      EW_GREEN: begin
        dwell_last = GREEN_LAST;
        next_phase = EW_YELLOW;
      end
      EW_YELLOW: begin
        dwell_last = YELLOW_LAST;
`ifdef TL4_ALL_RED_EN
        next_phase = ALL_RED_2;
`else
        next_phase = NS_GREEN;
`endif
      end
`ifdef TL4_ALL_RED_EN
      ALL_RED_1: begin
        dwell_last = ALLRED_LAST;
        next_phase = EW_GREEN;
      end
      ALL_RED_2: begin
        dwell_last = ALLRED_LAST;
        next_phase = NS_GREEN;
      end
`endif
      default: illegal = 1'b1;
    endcase

    if (illegal) begin
      state_d = NS_GREEN;
      cnt_d   = '0;
    end else if (cnt_q >= dwell_last) begin
      state_d = next_phase;
      cnt_d   = '0;
    end

    ns_d = LAMP_RED;
    ew_d = LAMP_RED;
    case (state_d)
      NS_GREEN:  ns_d = LAMP_GREEN;
      NS_YELLOW: ns_d = LAMP_YELLOW;
      EW_GREEN:  ew_d = LAMP_GREEN;
      EW_YELLOW: ew_d = LAMP_YELLOW;
      default: begin
        ns_d = LAMP_RED;
        ew_d = LAMP_RED;
      end
    endcase
  end

  // State, dwell counter and lamp registers; reset forces NS green at once.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= NS_GREEN;
      cnt_q   <= '0;
      ns_q    <= LAMP_GREEN;
      ew_q    <= LAMP_RED;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ns_q    <= ns_d;
      ew_q    <= ew_d;
    end
  end

  assign ns_light = ns_q;
  assign ew_light = ew_q;

endmodule

// File: tb/tb_traffic_light_4way.sv
// Bench for traffic_light_4way: three instances (defaults, 3/1/2 timing,
// zero-valued parameters) share clock and reset. A driver issues random
// asynchronous reset pulses and queues the expected lamps per cycle; a
// monitor pops and compares on each falling edge and checks lamp safety.
module tb_traffic_light_4way;

  localparam logic [2:0] RED = 3'b100;
  localparam logic [2:0] YEL = 3'b010;
  localparam logic [2:0] GRN = 3'b001;

  logic       clk;
  logic       reset;
  logic [2:0] ns0, ew0, ns1, ew1, ns2, ew2;

  typedef struct {
    int unsigned n;
    logic [5:0]  e0;
    logic [5:0]  e1;
    logic [5:0]  e2;
  } exp_t;

  exp_t        sb[$];
  int unsigned checks = 0;
  int unsigned errors = 0;

  traffic_light_4way dut0 (
    .clk(clk), .reset(reset), .ns_light(ns0), .ew_light(ew0)
  );

  traffic_light_4way #(
    .GREEN_TIME(3), .YELLOW_TIME(1), .ALLRED_TIME(2)
  ) dut1 (
    .clk(clk), .reset(reset), .ns_light(ns1), .ew_light(ew1)
  );

  traffic_light_4way #(
    .GREEN_TIME(0), .YELLOW_TIME(3), .ALLRED_TIME(0)
  ) dut2 (
    .clk(clk), .reset(reset), .ns_light(ns2), .ew_light(ew2)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference: lamps shown n clock periods after reset release, from the
  // phase durations laid end to end around one full cycle.
  function automatic logic [5:0] model(int unsigned g, int unsigned y,
                                       int unsigned a, int unsigned n);
    int unsigned ge, ye, ae, p;
    ge = (g == 0) ? 1 : g;
    ye = (y == 0) ? 1 : y;
`ifdef TL4_ALL_RED_EN
    ae = (a == 0) ? 1 : a;
`else
    ae = 0;
`endif
    p = n % (2 * (ge + ye + ae));
    if (p < ge)                     return {GRN, RED};
    else if (p < ge + ye)           return {YEL, RED};
    else if (p < ge + ye + ae)      return {RED, RED};
    else if (p < 2*ge + ye + ae)    return {RED, GRN};
    else if (p < 2*ge + 2*ye + ae)  return {RED, YEL};
    else                            return {RED, RED};
  endfunction

  task automatic chk(input string name, input logic [5:0] got,
                     input logic [5:0] want, input int unsigned n);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s n=%0d got ns=%b ew=%b expected ns=%b ew=%b",
               name, n, got[5:3], got[2:0], want[5:3], want[2:0]);
    end
  endtask

  task automatic safe(input string name, input logic [2:0] ns, input logic [2:0] ew);
    checks++;
    if (!($onehot(ns) && $onehot(ew) && (ns == RED || ew == RED))) begin
      errors++;
      $display("FAIL %s_safety got ns=%b ew=%b expected one-hot with at least one red",
               name, ns, ew);
    end
  endtask

  // Monitor: compare queued expectations against the lamps mid-cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("lamps_dflt", {ns0, ew0}, e.e0, e.n);
        chk("lamps_312",  {ns1, ew1}, e.e1, e.n);
        chk("lamps_zero", {ns2, ew2}, e.e2, e.n);
      end
      safe("dflt", ns0, ew0);
      safe("t312", ns1, ew1);
      safe("zero", ns2, ew2);
    end
  end

  // Driver: reset for the first cycle, a long undisturbed run, then random
  // reset pulses dropped between clock edges.
  initial begin
    int unsigned n;
    int unsigned hold;
    exp_t        e;
    reset = 1'b0;
    n     = 0;
    hold  = 0;
    for (int c = 0; c < 2000; c++) begin
      @(posedge clk);
      if (reset) n++;
      #2;
      if (c == 1) begin
        reset = 1'b1;
      end else if (hold > 0) begin
        hold--;
        if (hold == 0) reset = 1'b1;
      end else if (c > 40 && $urandom_range(0, 60) == 0) begin
        reset = 1'b0;
        n     = 0;
        hold  = $urandom_range(1, 3);
        #1;
        chk("async_reset_dflt", {ns0, ew0}, {GRN, RED}, n);
        chk("async_reset_312",  {ns1, ew1}, {GRN, RED}, n);
      end
      e.n  = n;
      e.e0 = model(5, 2, 1, n);
      e.e1 = model(3, 1, 2, n);
      e.e2 = model(0, 3, 0, n);
      sb.push_back(e);
    end
    for (int w = 0; w < 20 && sb.size() > 0; w++) @(negedge clk);
    #1;
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain got %0d pending expected 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/traffic_light_4way.md
TRAFFIC_LIGHT_4WAY -- requirements
Module: traffic_light_4way

Interface
REQ-001 SHALL have parameter GREEN_TIME, default 5, which sets the clock cycles a direction shows green.
REQ-002 SHALL have parameter YELLOW_TIME, default 2, which sets the clock cycles a direction shows yellow.
REQ-003 SHALL have parameter ALLRED_TIME, default 1, which sets the clock cycles of all-red clearance (used only when TL4_ALL_RED_EN is defined).
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all state changes occur on its rising edge.
REQ-005 SHALL have port reset, input, 1 bit: asynchronous, active-low reset (0 = reset asserted).
REQ-006 SHALL have port ns_light, output, 3 bits: north-south lamp, encoded {red,yellow,green}.
REQ-007 SHALL have port ew_light, output, 3 bits: east-west lamp, same encoding.

Function
REQ-008 Lamp encoding SHALL be: RED = 3'b100, YELLOW = 3'b010, GREEN = 3'b001; each output SHALL be exactly one-hot at all times.
REQ-009 The FSM SHALL have states NS_GREEN, NS_YELLOW, ALL_RED_1, EW_GREEN, EW_YELLOW, ALL_RED_2.
REQ-010 Outputs per state SHALL be: NS_GREEN ns=001/ew=100; NS_YELLOW ns=010/ew=100; EW_GREEN ns=100/ew=001; EW_YELLOW ns=100/ew=010; ALL_RED_x ns=100/ew=100.
REQ-011 Outputs SHALL be registered (Moore) and change only on a rising clk edge or on reset assertion.
REQ-012 Each state SHALL persist for exactly its parameter value in cycles, counted by a dwell counter that clears on every state change.
REQ-013 Transition order SHALL be NS_GREEN -> NS_YELLOW -> ALL_RED_1 -> EW_GREEN -> EW_YELLOW -> ALL_RED_2 -> NS_GREEN, cyclically.
REQ-014 With default parameters, one full cycle SHALL be 16 clocks (5+2+1+5+2+1).
REQ-015 The dwell counter SHALL be 8 bits wide; parameter values SHALL be legal in 1..255, and a value of 0 SHALL be treated as 1.
REQ-016 The design SHALL never present non-red on both ns_light and ew_light in the same cycle.
REQ-017 Any unreachable or illegal state encoding SHALL recover to NS_GREEN on the next clock, with the counter cleared.

Reset
REQ-018 While reset=0, the state SHALL be forced immediately, independent of clk, to NS_GREEN with the counter at 0, giving ns_light=001 and ew_light=100.
REQ-019 After reset deasserts, the first rising edge SHALL count as cycle 1 of NS_GREEN.
REQ-020 Reset asserted mid-phase SHALL abort the phase immediately and restart the sequence from REQ-018.

Configuration
REQ-021 With macro TL4_ALL_RED_EN defined, the ALL_RED_1 and ALL_RED_2 states SHALL be present with duration ALLRED_TIME.
REQ-022 Without TL4_ALL_RED_EN, NS_YELLOW SHALL go directly to EW_GREEN, EW_YELLOW SHALL go directly to NS_GREEN, and the default cycle length SHALL be 14 clocks; ALLRED_TIME SHALL be ignored.

Verification
REQ-023 Reset test: hold reset=0 for 1 cycle, then release -> ns=001 and ew=100 during reset and for 5 clocks after release.
REQ-024 Sequence test (macro on, defaults): run 32 clocks -> ns/ew go 001/100 x5, 010/100 x2, 100/100 x1, 100/001 x5, 100/010 x2, 100/100 x1, then the pattern repeats.
REQ-025 Macro off: run 28 clocks -> 001/100 x5, 010/100 x2, 100/001 x5, 100/010 x2, repeated, with no all-red cycle.
REQ-026 Async reset mid-EW_GREEN: drive reset=0 between clock edges -> ns=001 and ew=100 immediately, before the next edge.
REQ-027 Safety assertion over 1000 clocks with GREEN_TIME=3, YELLOW_TIME=1, ALLRED_TIME=2 -> no cycle where both outputs are non-red, and both outputs are one-hot every cycle.
